// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int DEFAULT_BAUD_DIV = 434;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for one asynchronous input bit.
module sync_bit #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= {STAGES{RESET_VAL}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receiver: centre-sampled 8N1 (8E1 with UART_RX_PARITY_EN) into a
// one-entry valid/ready buffer with framing/overrun pulses.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int BAUD_DIV    = DEFAULT_BAUD_DIV,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err_o
`endif
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_RELOAD = CW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tick;
    logic                 done;
    logic                 ferr;

    logic [7:0] data_q;
    logic       valid_q;
    logic       frame_q;
    logic       overrun_q;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic perr;
    logic parity_q;
`endif

    sync_bit #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_i),
        .q   (rx_s)
    );

    assign tick = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? FULL_RELOAD : cnt_q - CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        done    = 1'b0;
        ferr    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = HALF_RELOAD;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    par_d   = rx_s;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        done = ~(^{shift_q, par_q});
                        perr = ^{shift_q, par_q};
`else
                        done = 1'b1;
`endif
                    end else begin
                        ferr    = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A completing byte may replace the buffered one only when it is
    // being drained in the same cycle; otherwise the newcomer is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            frame_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            frame_q   <= ferr;
            overrun_q <= done && valid_q && !ready_i;
            if (done && (!valid_q || ready_i)) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= perr;
        end
    end

    assign parity_err_o = parity_q;
`endif

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboard bench for uart_rx_frontend at BAUD_DIV=8.
module tb_uart_rx_frontend;

    localparam int BAUD_DIV = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_i;
    logic       ready_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;
`ifdef UART_RX_PARITY_EN
    logic       parity_err_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_valid, n_ferr, n_ovr, n_perr, n_busy_lo, n_busy_hi;

    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_frontend #(
        .BAUD_DIV    (BAUD_DIV),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err_o(parity_err_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (valid_o === 1'b1) n_valid++;
            if (frame_err_o === 1'b1) n_ferr++;
            if (overrun_o === 1'b1) n_ovr++;
`ifdef UART_RX_PARITY_EN
            if (parity_err_o === 1'b1) n_perr++;
`endif
            if (busy_o === 1'b0) n_busy_lo++;
            if (busy_o === 1'b1) n_busy_hi++;
            if (valid_o === 1'b1 && ready_i === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", exp_q.size(), 1);
                end else begin
                    check("data", data_o, exp_q.pop_front());
                end
            end
        end
    end

    task automatic clear_counts();
        n_valid   = 0;
        n_ferr    = 0;
        n_ovr     = 0;
        n_perr    = 0;
        n_busy_lo = 0;
        n_busy_hi = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx_i = b;
        idle(BAUD_DIV);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic par_bad);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_bad);
`else
        if (par_bad) rx_i = 1'b1;
`endif
        drive_bit(stop);
    endtask

    initial begin
        rst     = 1'b1;
        rx_i    = 1'b0;
        ready_i = 1'b0;
        clear_counts();

        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_outs",
                  {data_o, valid_o, frame_err_o, overrun_o, busy_o}, 0);
        end

        // Line already low at release: the frame starts immediately
        @(posedge clk);
        #1;
        rst     = 1'b0;
        ready_i = 1'b1;
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 1'b0);
        idle(16);
        check("post_rst_valid_cnt", n_valid, 1);
        check("post_rst_sb_empty", exp_q.size(), 0);

        clear_counts();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(16);
        check("a5_valid_cnt", n_valid, 1);
        check("a5_ferr_cnt", n_ferr, 0);
        check("a5_ovr_cnt", n_ovr, 0);
        check("a5_sb_empty", exp_q.size(), 0);

        clear_counts();
        ready_i = 1'b0;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(16);
        @(negedge clk);
        check("ovr_valid", valid_o, 1);
        check("ovr_data", data_o, 8'h3C);
        check("ovr_cnt", n_ovr, 1);
        check("ovr_ferr_cnt", n_ferr, 0);
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        idle(3);
        @(negedge clk);
        check("drain_valid", valid_o, 0);
        check("drain_sb_empty", exp_q.size(), 0);

        @(posedge clk);
        #1;
        clear_counts();
        send_frame(8'h55, 1'b0, 1'b0);
        rx_i = 1'b0;
        n_busy_lo = 0;
        idle(20 * BAUD_DIV);
        check("brk_busy_lo_cnt", n_busy_lo, 0);
        check("brk_ferr_cnt", n_ferr, 1);
        check("brk_valid_cnt", n_valid, 0);
        rx_i = 1'b1;
        idle(5);
        @(negedge clk);
        check("brk_busy_end", busy_o, 0);

        @(posedge clk);
        #1;
        idle(4);
        clear_counts();
        rx_i = 1'b0;
        idle(2);
        rx_i = 1'b1;
        idle(12);
        @(negedge clk);
        check("glitch_seen", n_busy_hi != 0, 1);
        check("glitch_busy", busy_o, 0);
        check("glitch_valid_cnt", n_valid, 0);
        check("glitch_err_cnt", n_ferr + n_ovr, 0);

`ifdef UART_RX_PARITY_EN
        @(posedge clk);
        #1;
        clear_counts();
        send_frame(8'h07, 1'b1, 1'b1);
        idle(16);
        check("par_bad_perr_cnt", n_perr, 1);
        check("par_bad_valid_cnt", n_valid, 0);
        check("par_bad_ferr_cnt", n_ferr, 0);
        clear_counts();
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(16);
        check("par_ok_perr_cnt", n_perr, 0);
        check("par_ok_valid_cnt", n_valid, 1);
`endif

        check("final_sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
